// File: rtl/led_matrix_pkg.sv
// Shared types and defaults for the LED matrix scanner.
package led_matrix_pkg;

  localparam int COLS      = 10;
  localparam int ROWS      = 7;
  localparam int ROW_IDX_W = $clog2(ROWS);

  typedef logic [COLS-1:0] row_t;
  typedef enum logic {BUF0, BUF1} buf_sel_t;

  function automatic buf_sel_t other_buf(buf_sel_t b);
    return (b == BUF0) ? BUF1 : BUF0;
  endfunction

endpackage

// File: rtl/led_scan_timer.sv
// Dwell counter and row index for the scanner, plus frame-start and
// frame-boundary strobes decoded from the current count.
module led_scan_timer #(
  parameter  int ROWS  = 7,
  parameter  int DWELL = 2500,
  localparam int CW    = $clog2(DWELL),
  localparam int IW    = $clog2(ROWS)
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic [CW-1:0] cnt,
  output logic [IW-1:0] idx,
  output logic          sof,
  output logic          boundary
);
  import led_matrix_pkg::*;

  localparam logic [CW-1:0] CNT_MAX = CW'(DWELL - 1);
  localparam logic [IW-1:0] IDX_MAX = IW'(ROWS - 1);

  logic row_end;

  assign row_end  = (cnt == CNT_MAX);
  assign boundary = row_end && (idx == IDX_MAX);
  assign sof      = (cnt == '0) && (idx == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      idx <= '0;
    end else if (row_end) begin
      cnt <= '0;
      idx <= (idx == IDX_MAX) ? '0 : idx + 1'b1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/led_matrix_scanner.sv
// Double-buffered LED matrix row scanner with inter-row blanking and a
// frame-boundary swap handshake. Define LED_SCAN_PWM_EN to add brightness PWM.
module led_matrix_scanner #(
  parameter  int COLS  = led_matrix_pkg::COLS,
  parameter  int ROWS  = led_matrix_pkg::ROWS,
  parameter  int DWELL = 2500,
  parameter  int BLANK = 16,
  localparam int IW    = $clog2(ROWS),
  localparam int CW    = $clog2(DWELL)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            wr_en,
  input  logic [IW-1:0]   wr_row,
  input  logic [COLS-1:0] wr_data,
  input  logic            swap_req,
`ifdef LED_SCAN_PWM_EN
  input  logic [3:0]      brightness,
`endif
  output logic            swap_ack,
  output logic            frame_start,
  output logic [ROWS-1:0] row_n,
  output logic [COLS-1:0] col
);
  import led_matrix_pkg::*;

  logic [CW-1:0]            cnt;
  logic [IW-1:0]            idx;
  logic                     sof, boundary;
  buf_sel_t                 front;
  logic                     swap_done;
  logic [ROWS-1:0][COLS-1:0] front_rows;
  logic                     lit;

  led_scan_timer #(.ROWS(ROWS), .DWELL(DWELL)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .cnt      (cnt),
    .idx      (idx),
    .sof      (sof),
    .boundary (boundary)
  );

  // Each row holds both buffers; writes always target the one not on display.
  // An out-of-range wr_row matches no row and is dropped.
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    logic [COLS-1:0] buf0, buf1;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        buf0 <= '0;
        buf1 <= '0;
      end else if (wr_en && (wr_row == IW'(r))) begin
        if (front == BUF0) buf1 <= wr_data;
        else               buf0 <= wr_data;
      end
    end

    assign front_rows[r] = (front == BUF0) ? buf0 : buf1;
  end

  // Swap only at the frame boundary; the ack is held back one cycle so it
  // lines up with the frame_start of the frame that shows the new buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      front     <= BUF0;
      swap_done <= 1'b0;
    end else begin
      swap_done <= boundary && swap_req;
      if (boundary && swap_req) front <= other_buf(front);
    end
  end

`ifdef LED_SCAN_PWM_EN
  localparam int PW = CW + 5;
  logic [PW-1:0] phase, on_time;
  logic [4:0]    bright_p1;

  always_comb begin
    bright_p1 = {1'b0, brightness} + 5'd1;
    phase     = PW'(cnt) - PW'(BLANK);
    on_time   = (PW'(DWELL - BLANK) * PW'(bright_p1)) >> 4;
    lit       = (cnt >= CW'(BLANK)) && (phase < on_time);
  end
`else
  always_comb begin
    lit = (cnt >= CW'(BLANK));
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_n       <= '1;
      col         <= '0;
      frame_start <= 1'b0;
      swap_ack    <= 1'b0;
    end else begin
      frame_start <= sof;
      swap_ack    <= sof && swap_done;
      row_n       <= lit ? ~(ROWS'(1) << idx) : '1;
      col         <= lit ? front_rows[idx] : '0;
    end
  end

endmodule

// File: tb/tb_led_matrix_scanner.sv
// Scoreboard bench for led_matrix_scanner: a time-based reference model
// predicts every output cycle; a monitor compares on the falling edge.
module tb_led_matrix_scanner;
  import led_matrix_pkg::*;

  localparam int DWELL = 40;
  localparam int BLANK = 4;
  localparam int NR    = 7;
  localparam int NC    = 10;
  localparam int FRAME = NR * DWELL;

  typedef struct packed {
    logic [NR-1:0] row_n;
    row_t          col;
    logic          fs;
    logic          ack;
    logic          tmo;
  } exp_t;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 wr_en = 1'b0;
  logic [ROW_IDX_W-1:0] wr_row = '0;
  row_t                 wr_data = '0;
  logic                 swap_req = 1'b0;
`ifdef LED_SCAN_PWM_EN
  logic [3:0]           brightness = 4'd15;
`endif
  logic                 swap_ack, frame_start;
  logic [NR-1:0]        row_n;
  row_t                 col;

  exp_t q[$];
  int   nvec = 0;
  int   nbad = 0;

  // reference model state
  int   t;
  row_t mbuf [2][NR];
  int   mfront;
  bit   mpend;

  led_matrix_scanner #(.COLS(NC), .ROWS(NR), .DWELL(DWELL), .BLANK(BLANK)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_en       (wr_en),
    .wr_row      (wr_row),
    .wr_data     (wr_data),
    .swap_req    (swap_req),
`ifdef LED_SCAN_PWM_EN
    .brightness  (brightness),
`endif
    .swap_ack    (swap_ack),
    .frame_start (frame_start),
    .row_n       (row_n),
    .col         (col)
  );

  always #5 clk = ~clk;

  function automatic exp_t blank_exp();
    exp_t e;
    e.row_n = '1;
    e.col   = '0;
    e.fs    = 1'b0;
    e.ack   = 1'b0;
    e.tmo   = 1'b0;
    return e;
  endfunction

  task automatic model_reset();
    t      = 0;
    mfront = 0;
    mpend  = 1'b0;
    for (int b = 0; b < 2; b++)
      for (int r = 0; r < NR; r++) mbuf[b][r] = '0;
  endtask

  // Predict the outputs produced by the coming clock edge, then apply that
  // edge's write and swap to the model.
  task automatic model_edge(output exp_t e);
    int ph, rw;
    bit lit, bnd;
    ph  = t % DWELL;
    rw  = (t / DWELL) % NR;
    lit = (ph >= BLANK);
`ifdef LED_SCAN_PWM_EN
    lit = lit && ((ph - BLANK) < (((DWELL - BLANK) * (int'(brightness) + 1)) / 16));
`endif
    for (int i = 0; i < NR; i++) e.row_n[i] = !(lit && (i == rw));
    e.col = lit ? mbuf[mfront][rw] : '0;
    e.fs  = (ph == 0) && (rw == 0);
    e.ack = e.fs && mpend;
    e.tmo = 1'b0;
    bnd   = ((t % FRAME) == FRAME - 1);
    if (wr_en && (int'(wr_row) < NR)) mbuf[1 - mfront][int'(wr_row)] = wr_data;
    mpend = bnd && swap_req;
    if (mpend) mfront = 1 - mfront;
    t++;
  endtask

  task automatic tick();
    exp_t e;
    model_edge(e);
    @(posedge clk);
    q.push_back(e);
    #1;
  endtask

  task automatic hold_reset(input int n);
    @(posedge clk);
    #1;
    rst_n    = 1'b0;
    wr_en    = 1'b0;
    swap_req = 1'b0;
    q.push_back(blank_exp());
    repeat (n) begin
      @(posedge clk);
      q.push_back(blank_exp());
      #1;
    end
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic swap_until_ack();
    int   n;
    exp_t e;
    n = 0;
    swap_req = 1'b1;
    while (swap_ack !== 1'b1 && n < 2 * FRAME) begin
      tick();
      n++;
    end
    swap_req = 1'b0;
    if (n >= 2 * FRAME) begin
      e = blank_exp();
      e.tmo = 1'b1;
      q.push_back(e);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      while (q.size() > 0) begin
        e = q.pop_front();
        nvec++;
        if (e.tmo) begin
          nbad++;
          $display("FAIL swap_ack_wait: got no swap_ack within %0d cycles, want a pulse", 2 * FRAME);
        end else if ({row_n, col, frame_start, swap_ack} !== {e.row_n, e.col, e.fs, e.ack}) begin
          nbad++;
          $display("FAIL scan @%0t: got row_n=%b col=%h fs=%b ack=%b, want row_n=%b col=%h fs=%b ack=%b",
                   $time, row_n, col, frame_start, swap_ack, e.row_n, e.col, e.fs, e.ack);
        end
      end
    end
  end

  initial begin : stim
    model_reset();
    hold_reset(3);
    repeat (DWELL + 5) tick();

    // write to back buffer only: nothing appears until a swap
    wr_en = 1'b1; wr_row = 3; wr_data = 10'h0FC;
    tick();
    wr_en = 1'b0;
    repeat (FRAME) tick();
    swap_until_ack();
    repeat (FRAME) tick();

    // same pattern into new back buffer, plus an out-of-range write, then swap
    wr_en = 1'b1; wr_row = 3; wr_data = 10'h0FC;
    tick();
    wr_row = 7; wr_data = 10'h3FF;
    tick();
    wr_en = 1'b0;
    swap_until_ack();
    repeat (FRAME) tick();

    // write in the boundary cycle itself, together with the swap request
    while ((t % FRAME) != FRAME - 1) tick();
    wr_en = 1'b1; wr_row = 0; wr_data = 10'h2A5; swap_req = 1'b1;
    tick();
    wr_en = 1'b0;
    swap_until_ack();
    repeat (2 * DWELL) tick();

    // reset while a lit row is being driven
    while ((t % FRAME) != BLANK + 10) tick();
    hold_reset(2);
    repeat (FRAME + DWELL) tick();

`ifdef LED_SCAN_PWM_EN
    brightness = 4'd7;  repeat (FRAME) tick();
    brightness = 4'd15; repeat (FRAME) tick();
    brightness = 4'd0;  wr_en = 1'b1; wr_row = 1; wr_data = 10'h155; tick();
    wr_en = 1'b0; swap_until_ack(); repeat (FRAME) tick();
`endif

    // randomized traffic
    for (int k = 0; k < 6 * FRAME; k++) begin
      wr_en   = ($urandom_range(0, 5) == 0);
      wr_row  = ROW_IDX_W'($urandom_range(0, 7));
      wr_data = row_t'($urandom);
      if ((k % DWELL) == 0) swap_req = ($urandom_range(0, 2) == 0);
`ifdef LED_SCAN_PWM_EN
      if ((k % DWELL) == 0) brightness = 4'($urandom_range(0, 15));
`endif
      tick();
    end
    wr_en = 1'b0;
    swap_req = 1'b0;

    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
